// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte width, arbiter state encoding and ASCII constants for the UART transmit path
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        SEND     = 2'd2,
        HOLD     = 2'd3
    } arb_state_e;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr_i, cyclically
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N_REQ-1:0] rot;
    int               sum;

    // Rotate so bit 0 is the requester at ptr_i; scanning downwards leaves the nearest hit last.
    always_comb begin
        rot   = N_REQ'({req_i, req_i} >> ptr_i);
        win_o = '0;
        idx_o = '0;
        sum   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = int'(ptr_i) + k;
                if (sum >= N_REQ) begin
                    sum = sum - N_REQ;
                end
                idx_o = IDX_W'(sum);
                win_o = N_REQ'(1) << sum;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - per-packet round-robin arbiter sharing one UART transmitter
// Optional WAIT_RDY watchdog built when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = UART_DATA_W,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ack,
    output logic [N_REQ-1:0]        grant,
    input  logic                    tx_rdy,
    output logic                    tx_en,
    output logic [DATA_W-1:0]       tx_data,
    output logic                    busy,
    output logic                    err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               last_q, last_d;
    logic               tx_en_q, tx_en_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               release_pkt;
    logic [N_REQ-1:0]   pick_win;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx)
    );

    // The finished owner moves to the back of the queue.
    assign ptr_next = IDX_W'(wrap_inc(int'(gidx_q), N_REQ));

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [26:0] WD_MAX = '1;
    localparam logic [26:0] WD_LIM = 27'(TIMEOUT_CYC - 1);

    logic [26:0] wd_cnt_q;
    logic        wd_hit;
    logic        err_q, err_d;

    assign wd_hit = (wd_cnt_q >= WD_LIM);
    assign err    = err_q;

    // Held at zero outside WAIT_RDY, so every entry starts a fresh count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= err_d;
            if (state_q != WAIT_RDY) begin
                wd_cnt_q <= '0;
            end else if (wd_cnt_q != WD_MAX) begin
                wd_cnt_q <= wd_cnt_q + 27'd1;
            end
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYC;
    assign err            = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        last_d      = last_q;
        tx_data_d   = tx_data_q;
        tx_en_d     = 1'b0;
        ack_d       = '0;
        release_pkt = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = pick_win;
                    gidx_d  = pick_idx;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (!req[gidx_q]) begin
                    release_pkt = 1'b1;
                end else if (tx_rdy) begin
                    tx_en_d   = 1'b1;
                    ack_d     = grant_q;
                    tx_data_d = req_data[int'(gidx_q)*DATA_W +: DATA_W];
                    state_d   = SEND;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (wd_hit) begin
                    release_pkt = 1'b1;
                    err_d       = 1'b1;
                end
`endif
            end
            SEND: begin
                last_d  = req_last[gidx_q];
                state_d = HOLD;
            end
            HOLD: begin
                if (last_q) begin
                    release_pkt = 1'b1;
                end else begin
                    state_d = WAIT_RDY;
                end
            end
            default: state_d = IDLE;
        endcase
        if (release_pkt) begin
            grant_d  = '0;
            rr_ptr_d = ptr_next;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            last_q    <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            last_q    <= last_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign grant   = grant_q;
    assign req_ack = ack_q;
    assign tx_en   = tx_en_q;
    assign tx_data = tx_data_q;
    assign busy    = (state_q != IDLE);

endmodule
